// File: rtl/sf_pkg.sv
// Shared definitions for the combo-move path: move codes (also used by
// the injector), the controller serial word layout and scheduler states.
package sf_pkg;

    // Move codes presented on move_out. The low two bits of a real move
    // equal the index of the button that requested it.
    localparam logic [2:0] MOVE_DFP  = 3'b000;
    localparam logic [2:0] MOVE_DBK  = 3'b001;
    localparam logic [2:0] MOVE_BDFP = 3'b010;
    localparam logic [2:0] MOVE_FDFP = 3'b011;
    localparam logic [2:0] MOVE_NONE = 3'b100;

    // Controller serial word: bit n is the nth button shifted out after
    // ctrl_latch (1 = pressed in the injected stream).
    localparam int SER_A      = 0;
    localparam int SER_B      = 1;
    localparam int SER_SELECT = 2;
    localparam int SER_START  = 3;
    localparam int SER_UP     = 4;
    localparam int SER_DOWN   = 5;
    localparam int SER_LEFT   = 6;
    localparam int SER_RIGHT  = 7;

    // Scheduler state encodings
    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_ISSUE    = 2'b01;
    localparam logic [1:0] ST_RUN      = 2'b10;
    localparam logic [1:0] ST_COOLDOWN = 2'b11;

    function automatic logic [2:0] button_to_move(input logic [1:0] idx);
        return {1'b0, idx};
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// One button input: 2-FF synchroniser followed by a stability counter.
//   clk_system  system clock
//   reset_n     async active-low reset (level resets to released = 1)
//   raw         asynchronous active-low button
//   level       debounced button level
//   press       one-cycle pulse on a debounced 1 -> 0 transition
module sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_system,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk_system or negedge reset_n) begin
        if (!reset_n) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            level      <= 1'b1;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            press  <= 1'b0;
            // stable_cnt counts consecutive samples that disagree with level
            if (sync_2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                level      <= sync_2;
                stable_cnt <= '0;
                press      <= level;   // old level 1 -> new level 0
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// Debounces the four move buttons, queues presses round-robin into a FIFO
// and issues them one at a time to the injector with a frame cooldown.
//   clk_system, reset_n        clock, async active-low reset
//   move_select[3:0]           raw active-low buttons (dfp, dbk, bdfp, fdfp)
//   ctrl_latch                 async console latch, one pulse per frame
//   inj_busy, inj_done         injector accept level / completion pulse
//   move_out, move_valid       issued move request
//   queue_count                FIFO occupancy
//   overflow, timeout_err      sticky error flags
//   frame_count                free-running ctrl_latch edge count
//
// state    | meaning
// IDLE     | waiting for a queued move
// ISSUE    | request on move_out, waiting for inj_busy or frame timeout
// RUN      | injector executing the move
// COOLDOWN | counting frames before the next issue
module move_scheduler
    import sf_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int COOLDOWN_FRAMES = 2,
    parameter int TIMEOUT_FRAMES  = 8
) (
    input  logic       clk_system,
    input  logic       reset_n,
    input  logic [3:0] move_select,
    input  logic       ctrl_latch,
    input  logic       inj_busy,
    input  logic       inj_done,
    output logic [2:0] move_out,
    output logic       move_valid,
    output logic [2:0] queue_count,
    output logic       overflow,
    output logic       timeout_err,
    output logic [7:0] frame_count
);

    localparam int         PW      = $clog2(FIFO_DEPTH);
    localparam logic [2:0] DEPTH_Q = 3'(FIFO_DEPTH);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_FRAMES - 1);
    localparam logic [7:0] CD_LAST = 8'(COOLDOWN_FRAMES - 1);

    logic [3:0]    btn_level;
    logic [3:0]    btn_press;
    logic          latch_s1, latch_s2, latch_s3;
    logic          latch_rise;
    logic [3:0]    pend;
    logic [1:0]    rr_ptr;
    logic          grant_any;
    logic [1:0]    grant_idx;
    logic [3:0]    grant_vec;
    logic [2:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [2:0]    count;
    logic          full, push, pop;
    logic [1:0]    state;
    logic [7:0]    wait_cnt;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc (
            .clk_system (clk_system),
            .reset_n    (reset_n),
            .raw        (move_select[i]),
            .level      (btn_level[i]),
            .press      (btn_press[i])
        );
    end

    always_ff @(posedge clk_system or negedge reset_n) begin
        if (!reset_n) begin
            latch_s1 <= 1'b0;
            latch_s2 <= 1'b0;
            latch_s3 <= 1'b0;
        end else begin
            latch_s1 <= ctrl_latch;
            latch_s2 <= latch_s1;
            latch_s3 <= latch_s2;
        end
    end

    assign latch_rise = latch_s2 & ~latch_s3;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (pend[2'(rr_ptr + k)]) begin
                grant_any = 1'b1;
                grant_idx = 2'(rr_ptr + k);
            end
        end
    end

    assign grant_vec   = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
    assign full        = (count == DEPTH_Q);
    assign pop         = (state == ST_IDLE) && (count != 3'd0);
    // A full FIFO still takes the push when the head leaves this cycle.
    assign push        = grant_any && (!full || pop);
    assign queue_count = count;

    always_ff @(posedge clk_system) begin
        if (push) mem[wr_ptr] <= button_to_move(grant_idx);
    end

    always_ff @(posedge clk_system or negedge reset_n) begin
        if (!reset_n) begin
            pend     <= 4'b0000;
            rr_ptr   <= 2'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            // press and level both change on the same edge; the gate only
            // ties a queued press to a button that currently reads pressed
            pend <= (pend & ~grant_vec) | (btn_press & ~btn_level);
            if (grant_any) rr_ptr <= grant_idx + 2'd1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 3'd1;
            else if (pop && !push) count <= count - 3'd1;
            if (grant_any && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_system or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            move_out    <= MOVE_NONE;
            move_valid  <= 1'b0;
            timeout_err <= 1'b0;
            wait_cnt    <= 8'd0;
            frame_count <= 8'd0;
        end else begin
            if (latch_rise) frame_count <= frame_count + 8'd1;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        move_out   <= mem[rd_ptr];
                        move_valid <= 1'b1;
                        wait_cnt   <= 8'd0;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // an accept on the final timeout frame still wins
                    if (inj_busy) begin
                        move_valid <= 1'b0;
                        state      <= ST_RUN;
                    end else if (latch_rise) begin
                        if (wait_cnt == TO_LAST) begin
                            move_valid  <= 1'b0;
                            move_out    <= MOVE_NONE;
                            timeout_err <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (inj_done || !inj_busy) begin
                        move_out <= MOVE_NONE;
                        wait_cnt <= 8'd0;
                        state    <= ST_COOLDOWN;
                    end
                end
                ST_COOLDOWN: begin
                    if (COOLDOWN_FRAMES == 0) begin
                        state <= ST_IDLE;
                    end else if (latch_rise) begin
                        if (wait_cnt == CD_LAST) state <= ST_IDLE;
                        else                     wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with a cycle-level reference model.
module tb_move_scheduler;

    localparam int DEPTH = 4;
    localparam int DEB   = 4;
    localparam int COOL  = 2;
    localparam int TOUT  = 8;

    logic       clk_system = 1'b0;
    logic       reset_n;
    logic [3:0] move_select;
    logic       ctrl_latch;
    logic       inj_busy;
    logic       inj_done;
    logic [2:0] move_out;
    logic       move_valid;
    logic [2:0] queue_count;
    logic       overflow;
    logic       timeout_err;
    logic [7:0] frame_count;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk_system = ~clk_system;

    move_scheduler #(
        .FIFO_DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB),
        .COOLDOWN_FRAMES(COOL), .TIMEOUT_FRAMES(TOUT)
    ) dut (
        .clk_system  (clk_system),
        .reset_n     (reset_n),
        .move_select (move_select),
        .ctrl_latch  (ctrl_latch),
        .inj_busy    (inj_busy),
        .inj_done    (inj_done),
        .move_out    (move_out),
        .move_valid  (move_valid),
        .queue_count (queue_count),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .frame_count (frame_count)
    );

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases: 0 waiting for work, 1 request offered, 2 injector running,
    // 3 cooling down. Moves are button indices held in a queue.
    bit [3:0] m_s1, m_s2, m_lvl, m_press, m_pend;
    int       m_run [4];
    bit       m_l1, m_l2, m_l3;
    int       m_rr, m_phase, m_left;
    int       m_q [$];
    int       m_out, m_valid, m_ovf, m_to, m_fc;

    task automatic model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF; m_lvl = 4'hF; m_press = 4'h0; m_pend = 4'h0;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
        m_l1 = 0; m_l2 = 0; m_l3 = 0;
        m_rr = 0; m_phase = 0; m_left = 0;
        m_q.delete();
        m_out = 4; m_valid = 0; m_ovf = 0; m_to = 0; m_fc = 0;
    endtask

    task automatic model_step();
        bit rise;
        bit do_pop;
        int sz;
        int g;
        rise   = m_l2 && !m_l3;
        sz     = m_q.size();
        do_pop = (m_phase == 0) && (sz > 0);
        if (rise) m_fc = (m_fc + 1) % 256;

        g = -1;
        for (int k = 0; k < 4; k++)
            if (g < 0 && m_pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
        if (g >= 0) begin
            m_pend[g] = 1'b0;
            m_rr = (g + 1) % 4;
            if (sz < DEPTH || do_pop) m_q.push_back(g);
            else m_ovf = 1;
        end

        case (m_phase)
            0: if (do_pop) begin
                m_out = m_q.pop_front(); m_valid = 1; m_left = TOUT; m_phase = 1;
            end
            1: if (inj_busy) begin
                m_valid = 0; m_phase = 2;
            end else if (rise) begin
                m_left--;
                if (m_left == 0) begin m_valid = 0; m_out = 4; m_to = 1; m_phase = 0; end
            end
            2: if (inj_done || !inj_busy) begin
                m_out = 4; m_left = COOL; m_phase = 3;
            end
            default: if (m_left == 0) m_phase = 0;
                     else if (rise) begin
                         m_left--;
                         if (m_left == 0) m_phase = 0;
                     end
        endcase

        m_pend = m_pend | m_press;
        for (int b = 0; b < 4; b++) begin
            m_press[b] = 1'b0;
            if (m_s2[b] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_press[b] = m_lvl[b];
                    m_lvl[b]   = m_s2[b];
                    m_run[b]   = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_s2 = m_s1; m_s1 = move_select;
        m_l3 = m_l2; m_l2 = m_l1; m_l1 = ctrl_latch;
    endtask

    always @(posedge clk_system or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    always @(posedge clk_system) begin
        #2;
        if (cmp_en) begin
            check("cyc move_out",    int'(move_out),    m_out);
            check("cyc move_valid",  int'(move_valid),  m_valid);
            check("cyc queue_count", int'(queue_count), m_q.size());
            check("cyc overflow",    int'(overflow),    m_ovf);
            check("cyc timeout_err", int'(timeout_err), m_to);
            check("cyc frame_count", int'(frame_count), m_fc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_system);
    endtask

    task automatic tap(input int b);
        move_select[b] = 1'b0; tick(8);
        move_select[b] = 1'b1; tick(8);
    endtask

    task automatic latch_pulse();
        ctrl_latch = 1'b1; tick(2);
        ctrl_latch = 1'b0; tick(2);
    endtask

    task automatic wait_valid(input string name, input bit want, input int budget);
        int n;
        n = 0;
        while (move_valid !== want && n < budget) begin tick(1); n++; end
        tests++;
        if (move_valid !== want) begin
            fails++;
            $display("FAIL %s: move_valid=%0b after %0d cycles, expected %0b", name, move_valid, n, want);
        end
    endtask

    task automatic wait_queue(input string name, input int budget);
        int n;
        n = 0;
        while (queue_count == 3'd0 && n < budget) begin tick(1); n++; end
        check(name, int'(queue_count), 1);
    endtask

    task automatic accept_and_finish();
        inj_busy = 1'b1; tick(3);
        inj_busy = 1'b0; inj_done = 1'b1; tick(1);
        inj_done = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " move_out"},    int'(move_out),    4);
        check({tag, " move_valid"},  int'(move_valid),  0);
        check({tag, " queue_count"}, int'(queue_count), 0);
        check({tag, " overflow"},    int'(overflow),    0);
        check({tag, " timeout_err"}, int'(timeout_err), 0);
        check({tag, " frame_count"}, int'(frame_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1; move_select = 4'hF; ctrl_latch = 1'b0;
        inj_busy = 1'b0; inj_done = 1'b0;
        #1 reset_n = 1'b0;
        #1 cmp_en = 1'b1;
        tick(3);
        check_reset_values("reset");
        reset_n = 1'b1;
        tick(3);

        // 1: three-sample glitch is rejected, a held press is issued as dfp
        move_select[0] = 1'b0; tick(3);
        move_select[0] = 1'b1; tick(12);
        check("t1 glitch queue", int'(queue_count), 0);
        check("t1 glitch valid", int'(move_valid), 0);
        move_select[0] = 1'b0; tick(10);
        move_select[0] = 1'b1;
        wait_valid("t1 issue", 1'b1, 20);
        check("t1 move_out", int'(move_out), 0);
        check("t1 queue after pop", int'(queue_count), 0);

        // 3: accept five cycles after valid
        tick(4);
        inj_busy = 1'b1; tick(1);
        check("t3 valid drop", int'(move_valid), 0);
        check("t3 move held", int'(move_out), 0);

        // 2: dbk and fdfp pressed together while the injector runs
        move_select = 4'b0101; tick(8);
        move_select = 4'hF;
        wait_queue("t2 first push", 20);
        tick(1);
        check("t2 second push", int'(queue_count), 2);
        tick(8);

        // 3 continued: completion then two-frame cooldown
        inj_busy = 1'b0; inj_done = 1'b1; tick(1);
        inj_done = 1'b0; tick(6);
        check("t3 cooldown hold", int'(move_valid), 0);
        latch_pulse();
        check("t3 one frame", int'(move_valid), 0);
        latch_pulse();
        wait_valid("t3 next issue", 1'b1, 10);
        check("t3 rr first dbk", int'(move_out), 1);
        check("t3 frames", int'(frame_count), 2);
        accept_and_finish();
        latch_pulse(); latch_pulse();
        wait_valid("t3 third issue", 1'b1, 10);
        check("t3 rr then fdfp", int'(move_out), 3);
        accept_and_finish();
        latch_pulse(); latch_pulse();
        tick(4);
        check("t3 queue drained", int'(move_valid), 0);

        // 4: injector held running, five presses into a four-entry FIFO
        tap(2);
        wait_valid("t4 lead issue", 1'b1, 10);
        check("t4 lead bdfp", int'(move_out), 2);
        inj_busy = 1'b1; tick(2);
        tap(0); tap(1); tap(2); tap(3); tap(0);
        tick(4);
        check("t4 queue full", int'(queue_count), 4);
        check("t4 overflow", int'(overflow), 1);
        for (int i = 0; i < 4; i++) begin
            inj_busy = 1'b0; inj_done = 1'b1; tick(1);
            inj_done = 1'b0;
            latch_pulse(); latch_pulse();
            wait_valid("t4 drain issue", 1'b1, 10);
            check("t4 drain order", int'(move_out), i);
            if (i < 3) begin inj_busy = 1'b1; tick(2); end
        end

        // 5: fdfp never accepted, eight frames later it is discarded
        repeat (7) latch_pulse();
        check("t5 still waiting", int'(move_valid), 1);
        latch_pulse();
        tick(2);
        check("t5 valid", int'(move_valid), 0);
        check("t5 move_out", int'(move_out), 4);
        check("t5 timeout_err", int'(timeout_err), 1);
        check("t5 frames", int'(frame_count), 22);
        tick(5);
        check("t5 stays idle", int'(move_valid), 0);

        // 6: reset while running with three moves queued
        tap(1);
        wait_valid("t6 issue", 1'b1, 10);
        check("t6 dbk", int'(move_out), 1);
        inj_busy = 1'b1; tick(2);
        tap(0); tap(2); tap(3);
        tick(4);
        check("t6 queued", int'(queue_count), 3);
        reset_n = 1'b0;
        #1;
        check_reset_values("t6 async");
        tick(2);
        inj_busy = 1'b0;
        reset_n = 1'b1;
        tick(30);
        check("t6 no issue", int'(move_valid), 0);
        check("t6 empty", int'(queue_count), 0);
        tap(2);
        wait_valid("t6 new press", 1'b1, 10);
        check("t6 new bdfp", int'(move_out), 2);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
